// File: rtl/mos_pkg.sv
// -----------------------------------------------------------------------------
// mos_pkg
// Shared definitions for the cycle-based MOS pass-switch model.
//   - 2-bit 4-state encoding: 00 = 0, 01 = 1, 10 = Z, 11 = X
//   - logic4_t   : one encoded 4-state value
//   - resolve2   : pairwise wired resolution of two drivers on one node
//   - is_conflict: true when one driver is a strong 0 and the other a strong 1
// -----------------------------------------------------------------------------
package mos_pkg;

  typedef logic [1:0] logic4_t;

  localparam logic4_t L0 = 2'b00;
  localparam logic4_t L1 = 2'b01;
  localparam logic4_t LZ = 2'b10;
  localparam logic4_t LX = 2'b11;

  // Z yields to the other driver, equal drivers agree, anything else is X.
  function automatic logic4_t resolve2(input logic4_t a, input logic4_t b);
    logic4_t r;
    if (a == LZ) begin
      r = b;
    end else if (b == LZ) begin
      r = a;
    end else if (a == b) begin
      r = a;
    end else begin
      r = LX;
    end
    return r;
  endfunction

  function automatic logic is_conflict(input logic4_t a, input logic4_t b);
    return ((a == L0) && (b == L1)) || ((a == L1) && (b == L0));
  endfunction

endpackage

// File: rtl/mos_switch_cell.sv
// -----------------------------------------------------------------------------
// mos_switch_cell
// Combinational model of one nmos (IS_PMOS = 0) or pmos (IS_PMOS = 1) pass
// switch using the mos_pkg 4-state encoding.
// Ports:
//   src   in  2  source value
//   gate  in  2  gate value
//   drain out 2  drain value
// -----------------------------------------------------------------------------
module mos_switch_cell
  import mos_pkg::*;
#(
  parameter bit IS_PMOS = 1'b0
) (
  input  logic4_t src,
  input  logic4_t gate,
  output logic4_t drain
);

  // Gate level that makes the channel conduct, and the one that cuts it off.
  localparam logic4_t GATE_ON  = IS_PMOS ? L0 : L1;
  localparam logic4_t GATE_OFF = IS_PMOS ? L1 : L0;

  // Pass-switch truth table; an unknown gate can only leave a floating source floating.
  always_comb begin
    drain = LX;
    if (gate == GATE_ON) begin
      drain = src;
    end else if (gate == GATE_OFF) begin
      drain = LZ;
    end else if (src == LZ) begin
      drain = LZ;
    end else begin
      drain = LX;
    end
  end

endmodule

// File: rtl/mos_switch_array.sv
// -----------------------------------------------------------------------------
// mos_switch_array
// N MOS pass switches whose drains tie to one shared node. Each cell's drain
// and the resolved node are registered together, so every output reflects the
// src/gate values sampled one rising edge earlier.
// Parameters:
//   N          number of cells (1..16)
//   PMOS_MASK  bit i = 1 makes cell i a pmos, 0 an nmos
// Ports:
//   clk         in   1    rising-edge clock
//   rst         in   1    synchronous active-high reset
//   src         in   2*N  per-cell source, cell i at [2i+1:2i]
//   gate        in   2*N  per-cell gate
//   drain       out  2*N  registered per-cell drain
//   node        out  2    registered resolved node value
//   contention  out  1    registered; a 0 driver and a 1 driver both present
//   node_x      out  1    registered; node resolved to X
// -----------------------------------------------------------------------------
module mos_switch_array
  import mos_pkg::*;
#(
  parameter int           N         = 4,
  parameter logic [N-1:0] PMOS_MASK = {N{1'b0}}
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*N-1:0] src,
  input  logic [2*N-1:0] gate,
  output logic [2*N-1:0] drain,
  output logic [1:0]     node,
  output logic           contention,
  output logic           node_x
);

  logic [2*N-1:0] w_drain;
  logic4_t        w_node;
  logic           w_any0;
  logic           w_any1;
  logic           w_contention;

  logic [2*N-1:0] r_drain;
  logic4_t        r_node;
  logic           r_contention;
  logic           r_node_x;

  for (genvar i = 0; i < N; i++) begin : g_cell
    mos_switch_cell #(
      .IS_PMOS (PMOS_MASK[i])
    ) u_cell (
      .src   (src[2*i +: 2]),
      .gate  (gate[2*i +: 2]),
      .drain (w_drain[2*i +: 2])
    );
  end

  // Fold the drains onto the node; 0/1 presence is tracked separately so an
  // X driver elsewhere cannot hide a 0-vs-1 fight.
  always_comb begin
    w_node = LZ;
    w_any0 = 1'b0;
    w_any1 = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_node = resolve2(w_node, w_drain[2*i +: 2]);
      w_any0 = w_any0 | (w_drain[2*i +: 2] == L0);
      w_any1 = w_any1 | (w_drain[2*i +: 2] == L1);
    end
    w_contention = is_conflict(w_any0 ? L0 : LZ, w_any1 ? L1 : LZ);
  end

  // Output registers, all loaded on the same edge so drain and node never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_drain      <= {N{LZ}};
      r_node       <= LZ;
      r_contention <= 1'b0;
      r_node_x     <= 1'b0;
    end else begin
      r_drain      <= w_drain;
      r_node       <= w_node;
      r_contention <= w_contention;
      r_node_x     <= (w_node == LX);
    end
  end

  assign drain      = r_drain;
  assign node       = r_node;
  assign contention = r_contention;
  assign node_x     = r_node_x;

endmodule

// File: tb/tb_mos_switch_array.sv
// -----------------------------------------------------------------------------
// tb_mos_switch_array
// Four instances with different sizes and device mixes share one clock and
// reset. After every rising edge each instance is compared with a counting
// reference model evaluated on the inputs that edge sampled; directed steps
// also compare against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_mos_switch_array;

  logic clk;
  logic rst;

  logic [1:0] src1,  gate1,  d1;
  logic [1:0] src1p, gate1p, d1p;
  logic [3:0] src2,  gate2,  d2;
  logic [7:0] src4,  gate4,  d4;
  logic [1:0] n1, n1p, n2, n4;
  logic       c1, c1p, c2, c4;
  logic       x1, x1p, x2, x4;

  int n_tests;
  int n_fail;

  mos_switch_array #(.N(1), .PMOS_MASK(1'b0)) u_n1 (
    .clk(clk), .rst(rst), .src(src1), .gate(gate1),
    .drain(d1), .node(n1), .contention(c1), .node_x(x1));

  mos_switch_array #(.N(1), .PMOS_MASK(1'b1)) u_p1 (
    .clk(clk), .rst(rst), .src(src1p), .gate(gate1p),
    .drain(d1p), .node(n1p), .contention(c1p), .node_x(x1p));

  mos_switch_array #(.N(2), .PMOS_MASK(2'b10)) u_n2 (
    .clk(clk), .rst(rst), .src(src2), .gate(gate2),
    .drain(d2), .node(n2), .contention(c2), .node_x(x2));

  mos_switch_array #(.N(4), .PMOS_MASK(4'b0110)) u_n4 (
    .clk(clk), .rst(rst), .src(src4), .gate(gate4),
    .drain(d4), .node(n4), .contention(c4), .node_x(x4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: classify each cell's drain, then count 0/1/X drivers.
  task automatic model(input int n, input logic [15:0] mask, input logic rst_v,
                       input logic [31:0] s, input logic [31:0] g,
                       output logic [31:0] d, output logic [1:0] nd,
                       output logic ct, output logic nx);
    int c0, c1n, cx;
    logic [1:0] si, gi, di;
    logic conducts, blocks;
    d = 32'h0; c0 = 0; c1n = 0; cx = 0;
    for (int i = 0; i < n; i++) begin
      si = s[2*i +: 2];
      gi = g[2*i +: 2];
      conducts = mask[i] ? (gi == 2'b00) : (gi == 2'b01);
      blocks   = mask[i] ? (gi == 2'b01) : (gi == 2'b00);
      if (rst_v)          di = 2'b10;
      else if (conducts)  di = si;
      else if (blocks)    di = 2'b10;
      else if (si == 2'b10) di = 2'b10;
      else                di = 2'b11;
      d[2*i +: 2] = di;
      if (di == 2'b00) c0++;
      if (di == 2'b01) c1n++;
      if (di == 2'b11) cx++;
    end
    ct = (c0 > 0) && (c1n > 0);
    if (cx > 0 || ct)  nd = 2'b11;
    else if (c1n > 0)  nd = 2'b01;
    else if (c0 > 0)   nd = 2'b00;
    else               nd = 2'b10;
    nx = (nd == 2'b11);
  endtask

  task automatic chk_dut(input string tag, input int n, input logic [15:0] mask,
                         input logic [31:0] s, input logic [31:0] g,
                         input logic [31:0] od, input logic [1:0] on,
                         input logic oc, input logic ox);
    logic [31:0] ed;
    logic [1:0]  en;
    logic        ec, ex;
    model(n, mask, rst, s, g, ed, en, ec, ex);
    chk($sformatf("%s.drain", tag), od, ed);
    chk($sformatf("%s.node", tag), {30'd0, on}, {30'd0, en});
    chk($sformatf("%s.contention", tag), {31'd0, oc}, {31'd0, ec});
    chk($sformatf("%s.node_x", tag), {31'd0, ox}, {31'd0, ex});
  endtask

  task automatic check_all(input string tag);
    chk_dut({tag, "/n1"}, 1, 16'h0001 & 16'h0000, {30'd0, src1}, {30'd0, gate1}, {30'd0, d1}, n1, c1, x1);
    chk_dut({tag, "/p1"}, 1, 16'h0001, {30'd0, src1p}, {30'd0, gate1p}, {30'd0, d1p}, n1p, c1p, x1p);
    chk_dut({tag, "/n2"}, 2, 16'h0002, {28'd0, src2}, {28'd0, gate2}, {28'd0, d2}, n2, c2, x2);
    chk_dut({tag, "/n4"}, 4, 16'h0006, {24'd0, src4}, {24'd0, gate4}, {24'd0, d4}, n4, c4, x4);
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    src1  = 2'($urandom); gate1  = 2'($urandom);
    src1p = 2'($urandom); gate1p = 2'($urandom);
    src2  = 4'($urandom); gate2  = 4'($urandom);
    src4  = 8'($urandom); gate4  = 8'($urandom);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Reset held two edges with arbitrary inputs.
    rst = 1'b1;
    randomize_inputs();
    #2;
    for (int k = 0; k < 2; k++) begin
      edge_step();
      check_all("reset");
      chk("reset.n4_drain", {24'd0, d4}, 32'h0000_00AA);
      randomize_inputs();
    end
    rst = 1'b0;

    // Step A: nmos on with src 0, pmos on with src 1, pull-up active, agreeing drivers.
    src1 = 2'b00;  gate1 = 2'b01;
    src1p = 2'b01; gate1p = 2'b00;
    src2 = 4'b01_00; gate2 = 4'b00_00;
    src4 = 8'h55;  gate4 = 8'h55;
    edge_step();
    check_all("stepA");
    chk("A.n1_drain", {30'd0, d1}, 32'd0);
    chk("A.n1_node", {30'd0, n1}, 32'd0);
    chk("A.p1_drain", {30'd0, d1p}, 32'd1);
    chk("A.n2_node", {30'd0, n2}, 32'd1);
    chk("A.n2_cont", {31'd0, c2}, 32'd0);
    chk("A.n4_node", {30'd0, n4}, 32'd1);
    chk("A.n4_cont", {31'd0, c4}, 32'd0);

    // Step B: switches off; pull-down only.
    gate1 = 2'b00;
    gate1p = 2'b01;
    gate2 = 4'b01_01;
    edge_step();
    check_all("stepB");
    chk("B.n1_drain", {30'd0, d1}, 32'd2);
    chk("B.p1_drain", {30'd0, d1p}, 32'd2);
    chk("B.n2_node", {30'd0, n2}, 32'd0);

    // Step C: X gate with driven source; both pair devices conducting.
    gate1 = 2'b11; src1 = 2'b01;
    gate2 = 4'b00_01;
    edge_step();
    check_all("stepC");
    chk("C.n1_drain", {30'd0, d1}, 32'd3);
    chk("C.n1_node_x", {31'd0, x1}, 32'd1);
    chk("C.n2_node", {30'd0, n2}, 32'd3);
    chk("C.n2_cont", {31'd0, c2}, 32'd1);
    chk("C.n2_node_x", {31'd0, x2}, 32'd1);

    // Mid-run reset for one edge while contention is active, then resume.
    rst = 1'b1;
    edge_step();
    check_all("midrst");
    chk("M.n2_cont", {31'd0, c2}, 32'd0);
    chk("M.n2_node", {30'd0, n2}, 32'd2);
    rst = 1'b0;
    edge_step();
    check_all("resume");
    chk("R.n2_cont", {31'd0, c2}, 32'd1);

    // Random traffic with occasional reset.
    for (int k = 0; k < 300; k++) begin
      randomize_inputs();
      rst = ($urandom_range(0, 19) == 0);
      edge_step();
      check_all($sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
